// File: rtl/dlx_dot4_mac_pkg.sv
// Shared TinyML DLX types and constants.
// Lane geometry, FSM states and 32-bit saturation helpers.
package dlx_tinyml_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FIN
  } dot_state_e;

  localparam int DOT_LANES  = 4;
  localparam int DOT_LANE_W = 8;

  localparam logic [31:0] SAT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT32_MIN = 32'h8000_0000;

  // In range iff the top three bits of the 34-bit sum agree.
  function automatic logic ovf34(input logic [33:0] s);
    return !((s[33:31] == 3'b000) || (s[33:31] == 3'b111));
  endfunction

  function automatic logic [31:0] sat32(input logic [33:0] s);
    if (ovf34(s)) begin
      return s[33] ? SAT32_MIN : SAT32_MAX;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/dlx_dot4_mac_if.sv
// Request/result bundle of the packed dot-product unit.
// Master issues operands; slave returns BUSY/DONE/RESULT/OVF.
interface dlx_dot4_mac_if;

  logic        START;
  logic        ACC_EN;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] ACC_IN;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic        OVF;

  modport master (
    output START,
    output ACC_EN,
    output A,
    output B,
    output ACC_IN,
    input  BUSY,
    input  DONE,
    input  RESULT,
    input  OVF
  );

  modport slave (
    input  START,
    input  ACC_EN,
    input  A,
    input  B,
    input  ACC_IN,
    output BUSY,
    output DONE,
    output RESULT,
    output OVF
  );

endinterface

// File: rtl/dlx_dot4_mac_lane_mul.sv
// Shared signed lane multiplier.
// Full-precision W x W -> 2W product, purely combinational.
module dlx_lane_mul #(
  parameter int W = 8
) (
  input  logic signed [W-1:0]   a_i,
  input  logic signed [W-1:0]   b_i,
  output logic signed [2*W-1:0] p_o
);

  assign p_o = a_i * b_i;

endmodule

// File: rtl/dlx_dot4_mac.sv
// Multi-cycle signed packed dot-product/accumulate unit.
// One lane pair per cycle through a shared multiplier.
module dlx_dot4_mac
  import dlx_tinyml_pkg::*;
#(
  parameter int LANES  = DOT_LANES,
  parameter int LANE_W = DOT_LANE_W,
  parameter bit SAT    = 1'b1
) (
  input  logic           CLK,
  input  logic           RST_N,
  dlx_dot4_mac_if.slave  bus
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW = 2 * LANE_W;

  if (LANES * LANE_W != 32) begin : g_geom_chk
    $error("dlx_dot4_mac: LANES*LANE_W must equal 32");
  end

  dot_state_e  state_q;
  logic [LW-1:0] lane_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [33:0] sum_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;
  logic        ovf_q;

  logic signed [LANE_W-1:0] la;
  logic signed [LANE_W-1:0] lb;
  logic signed [PW-1:0]     prod;
  logic [33:0] prod_x;
  logic [33:0] base_d;
  logic [33:0] sum_d;
  logic        last;

  assign la = a_q[lane_q*LANE_W +: LANE_W];
  assign lb = b_q[lane_q*LANE_W +: LANE_W];

  dlx_lane_mul #(
    .W (LANE_W)
  ) u_mul (
    .a_i (la),
    .b_i (lb),
    .p_o (prod)
  );

  assign prod_x = {{(34-PW){prod[PW-1]}}, prod};
  assign base_d = bus.ACC_EN ? {{2{bus.ACC_IN[31]}}, bus.ACC_IN} : '0;
  assign sum_d  = sum_q + prod_x;
  assign last   = (lane_q == LW'(LANES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // BUSY drops one cycle after DONE unless a new op starts.
          busy_q <= bus.START;
          if (bus.START) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            sum_q   <= base_d;
            lane_q  <= '0;
            state_q <= MUL;
          end
        end
        MUL: begin
          sum_q  <= sum_d;
          lane_q <= last ? '0 : lane_q + 1'b1;
          if (last) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          result_q <= SAT ? sat32(sum_q) : sum_q[31:0];
          ovf_q    <= ovf34(sum_q);
          done_q   <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.BUSY   = busy_q;
  assign bus.DONE   = done_q;
  assign bus.RESULT = result_q;
  assign bus.OVF    = ovf_q;

endmodule
